// File: rtl/pc_seq_ctrl_pkg.sv
// Shared types and default constants for the fetch sequencer.
package pc_seq_pkg;

    localparam int          DEF_PC_W     = 10;
    localparam int          DEF_INC      = 4;
    localparam logic [9:0]  DEF_RESET_PC = 10'd0;
    localparam logic [9:0]  DEF_TRAP_VEC = 10'h3F0;

    // Sequencer states
    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        FETCH    = 2'd1,
        HALTED   = 2'd2
    } state_t;

    // Redirect kinds; the numeric order is the priority order
    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        JMP  = 2'd2,
        TRAP = 2'd3
    } redir_kind_t;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Redirect inputs and instruction-memory port of the fetch sequencer.
interface pc_seq_ctrl_if #(
    parameter int PC_W = 10
);
    logic            stall_i;
    logic            br_taken_i;
    logic [PC_W-1:0] br_target_i;
    logic            jmp_i;
    logic [PC_W-1:0] jmp_target_i;
    logic            trap_i;
    logic            halt_i;
    logic            imem_req_o;
    logic [PC_W-1:0] imem_addr_o;
    logic            imem_ack_i;
    logic [PC_W-1:0] pc_o;
    logic            inst_valid_o;
    logic            flush_o;
    logic            misalign_o;

    // Sequencer side
    modport master (
        input  stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
               trap_i, halt_i, imem_ack_i,
        output imem_req_o, imem_addr_o, pc_o, inst_valid_o, flush_o, misalign_o
    );

    // Decode/execute and memory side
    modport slave (
        output stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
               trap_i, halt_i, imem_ack_i,
        input  imem_req_o, imem_addr_o, pc_o, inst_valid_o, flush_o, misalign_o
    );
endinterface

// File: rtl/pc_seq_ctrl_pc_next_sel.sv
// Combinational next-PC selector: merges the live redirect pulses with the
// pending capture, applies priority, and redirects misaligned targets to the trap vector.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INC      = DEF_INC,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(DEF_TRAP_VEC)
) (
    input  logic [PC_W-1:0] pc,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            trap,
    input  redir_kind_t     pend_kind,
    input  logic [PC_W-1:0] pend_target,
    output redir_kind_t     cur_kind,
    output logic [PC_W-1:0] cur_target,
    output logic [PC_W-1:0] next_pc,
    output logic            misalign,
    output logic            flush
);
    localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

    redir_kind_t     sel_kind;
    logic [PC_W-1:0] sel_target;

    // Highest-priority redirect arriving this cycle
    always_comb begin
        cur_kind   = NONE;
        cur_target = '0;
        if (trap) begin
            cur_kind = TRAP;
        end else if (jmp) begin
            cur_kind   = JMP;
            cur_target = jmp_target;
        end else if (br_taken) begin
            cur_kind   = BR;
            cur_target = br_target;
        end
    end

    // Pick live vs pending (a live pulse of equal rank is newer), then form the next PC
    always_comb begin
        sel_kind   = pend_kind;
        sel_target = pend_target;
        if (cur_kind != NONE && cur_kind >= pend_kind) begin
            sel_kind   = cur_kind;
            sel_target = cur_target;
        end
        next_pc  = pc + INC_V;
        misalign = 1'b0;
        flush    = (sel_kind != NONE);
        case (sel_kind)
            TRAP: next_pc = TRAP_VEC;
            JMP, BR: begin
                if (sel_target[1:0] != 2'b00) begin
                    next_pc  = TRAP_VEC;
                    misalign = 1'b1;
                end else begin
                    next_pc = sel_target;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer: owns the PC register, handshakes with instruction memory,
// holds on stalls and remembers redirects that arrive while no fetch is accepted.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
    parameter int              INC      = DEF_INC,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(DEF_TRAP_VEC)
) (
    input  logic             clk,
    input  logic             rst,
    pc_seq_ctrl_if.master    bus
);
    state_t          state_reg, state_next;
    redir_kind_t     pend_kind_reg, pend_kind_next;
    logic [PC_W-1:0] pend_target_reg, pend_target_next;
    logic [PC_W-1:0] pc_reg, pc_next;

    logic            imem_req;
    logic            accept;
    redir_kind_t     cur_kind;
    logic [PC_W-1:0] cur_target;
    logic [PC_W-1:0] sel_next_pc;
    logic            sel_misalign;
    logic            sel_flush;

    assign imem_req = (state_reg == FETCH) && !bus.stall_i;
    assign accept   = imem_req && bus.imem_ack_i;

    pc_next_sel #(
        .PC_W     (PC_W),
        .INC      (INC),
        .TRAP_VEC (TRAP_VEC)
    ) u_sel (
        .pc          (pc_reg),
        .br_taken    (bus.br_taken_i),
        .br_target   (bus.br_target_i),
        .jmp         (bus.jmp_i),
        .jmp_target  (bus.jmp_target_i),
        .trap        (bus.trap_i),
        .pend_kind   (pend_kind_reg),
        .pend_target (pend_target_reg),
        .cur_kind    (cur_kind),
        .cur_target  (cur_target),
        .next_pc     (sel_next_pc),
        .misalign    (sel_misalign),
        .flush       (sel_flush)
    );

    // State, pending redirect and PC registers; reset aborts any fetch in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= RST_HOLD;
            pend_kind_reg   <= NONE;
            pend_target_reg <= '0;
            pc_reg          <= RESET_PC;
        end else begin
            state_reg       <= state_next;
            pend_kind_reg   <= pend_kind_next;
            pend_target_reg <= pend_target_next;
            pc_reg          <= pc_next;
        end
    end

    // Next state, PC update on accepted fetch, redirect capture otherwise
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pend_kind_next   = pend_kind_reg;
        pend_target_next = pend_target_reg;
        case (state_reg)
            RST_HOLD: state_next = FETCH;
            FETCH: begin
                if (bus.halt_i) state_next = HALTED;
                if (accept) begin
                    pc_next          = sel_next_pc;
                    pend_kind_next   = NONE;
                    pend_target_next = '0;
                end else if (cur_kind != NONE && cur_kind >= pend_kind_reg) begin
                    pend_kind_next   = cur_kind;
                    pend_target_next = cur_target;
                end
            end
            default: state_next = HALTED;
        endcase
    end

    assign bus.imem_req_o   = imem_req;
    assign bus.imem_addr_o  = pc_reg;
    assign bus.pc_o         = pc_reg;
    assign bus.inst_valid_o = accept && !sel_flush;
    assign bus.flush_o      = accept && sel_flush;
    assign bus.misalign_o   = accept && sel_misalign;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for the fetch sequencer with hand-computed expectations.
module tb_pc_seq_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    pc_seq_ctrl_if #(.PC_W(10)) bus ();

    pc_seq_ctrl #(
        .PC_W     (10),
        .RESET_PC (10'd0),
        .INC      (4),
        .TRAP_VEC (10'h3F0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs just after the falling edge, then settle
    task automatic step(input logic st, input logic br, input logic [9:0] brt,
                        input logic jm, input logic [9:0] jt, input logic tr,
                        input logic hl, input logic ak);
        @(negedge clk);
        bus.stall_i      = st;
        bus.br_taken_i   = br;
        bus.br_target_i  = brt;
        bus.jmp_i        = jm;
        bus.jmp_target_i = jt;
        bus.trap_i       = tr;
        bus.halt_i       = hl;
        bus.imem_ack_i   = ak;
        #1;
        $display("t=%0t pc=%03h req=%0b ack=%0b valid=%0b flush=%0b mis=%0b",
                 $time, bus.pc_o, bus.imem_req_o, ak, bus.inst_valid_o,
                 bus.flush_o, bus.misalign_o);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.stall_i = 0; bus.br_taken_i = 0; bus.br_target_i = '0;
        bus.jmp_i = 0; bus.jmp_target_i = '0; bus.trap_i = 0;
        bus.halt_i = 0; bus.imem_ack_i = 0;

        // Held in reset
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_pc", bus.pc_o, 10'd0);
        check_eq("rst_req", bus.imem_req_o, 0);
        check_eq("rst_valid", bus.inst_valid_o, 0);

        // Release: one hold cycle, then free-run with ack
        @(negedge clk);
        rst = 1'b1;
        bus.imem_ack_i = 1'b1;
        #1;
        check_eq("hold_pc", bus.pc_o, 10'd0);
        check_eq("hold_req", bus.imem_req_o, 0);

        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("run0_pc", bus.pc_o, 10'd0);
        check_eq("run0_req", bus.imem_req_o, 1);
        check_eq("run0_valid", bus.inst_valid_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("run4_pc", bus.pc_o, 10'd4);
        check_eq("run4_valid", bus.inst_valid_o, 1);

        // Ack withheld three cycles at PC 8 with a branch during the wait
        step(0, 1, 10'h040, 0, 0, 0, 0, 0);
        check_eq("wait1_pc", bus.pc_o, 10'd8);
        check_eq("wait1_addr", bus.imem_addr_o, 10'd8);
        check_eq("wait1_req", bus.imem_req_o, 1);
        check_eq("wait1_valid", bus.inst_valid_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("wait2_pc", bus.pc_o, 10'd8);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("wait3_pc", bus.pc_o, 10'd8);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("ackbr_flush", bus.flush_o, 1);
        check_eq("ackbr_valid", bus.inst_valid_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("br_pc", bus.pc_o, 10'h040);
        check_eq("br_valid", bus.inst_valid_o, 1);
        check_eq("br_flush", bus.flush_o, 0);

        // Trap, jump and branch together: trap wins
        step(0, 1, 10'h080, 1, 10'h100, 1, 0, 1);
        check_eq("trio_pc", bus.pc_o, 10'h044);
        check_eq("trio_flush", bus.flush_o, 1);
        check_eq("trio_mis", bus.misalign_o, 0);
        // Misaligned jump
        step(0, 0, 0, 1, 10'h102, 0, 0, 1);
        check_eq("trap_pc", bus.pc_o, 10'h3F0);
        check_eq("misj_mis", bus.misalign_o, 1);
        check_eq("misj_flush", bus.flush_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("misj_pc", bus.pc_o, 10'h3F0);
        check_eq("misj_mis_off", bus.misalign_o, 0);
        check_eq("misj_valid", bus.inst_valid_o, 1);

        // Sequential wrap past the top of the address space
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("seq_3f4", bus.pc_o, 10'h3F4);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("seq_3f8", bus.pc_o, 10'h3F8);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("seq_3fc", bus.pc_o, 10'h3FC);

        // Stall two cycles with ack high; jump then lower-priority branch captured
        step(1, 0, 0, 1, 10'h300, 0, 0, 1);
        check_eq("wrap_pc", bus.pc_o, 10'h000);
        check_eq("stall1_req", bus.imem_req_o, 0);
        check_eq("stall1_valid", bus.inst_valid_o, 0);
        check_eq("stall1_flush", bus.flush_o, 0);
        step(1, 1, 10'h040, 0, 0, 0, 0, 1);
        check_eq("stall2_pc", bus.pc_o, 10'h000);
        check_eq("stall2_req", bus.imem_req_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("unstall_pc", bus.pc_o, 10'h000);
        check_eq("unstall_req", bus.imem_req_o, 1);
        check_eq("unstall_flush", bus.flush_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("pend_jmp_pc", bus.pc_o, 10'h300);
        check_eq("pend_wait_req", bus.imem_req_o, 1);

        // Asynchronous reset mid-wait
        #1;
        rst = 1'b0;
        #1;
        check_eq("arst_pc", bus.pc_o, 10'd0);
        check_eq("arst_req", bus.imem_req_o, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.imem_ack_i = 1'b1;
        #1;
        check_eq("rehold_req", bus.imem_req_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("refetch_pc", bus.pc_o, 10'd0);
        check_eq("refetch_req", bus.imem_req_o, 1);

        // Halt during an ack cycle: that fetch completes, then fetching stops
        step(0, 0, 0, 0, 0, 0, 1, 1);
        check_eq("halt_pc", bus.pc_o, 10'd4);
        check_eq("halt_valid", bus.inst_valid_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("halted_pc", bus.pc_o, 10'd8);
        check_eq("halted_req", bus.imem_req_o, 0);
        check_eq("halted_valid", bus.inst_valid_o, 0);
        step(0, 1, 10'h040, 0, 0, 0, 0, 1);
        check_eq("halted2_pc", bus.pc_o, 10'd8);
        check_eq("halted2_req", bus.imem_req_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("halted3_pc", bus.pc_o, 10'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
